// File: rtl/bitonic_network_8.sv
// Pipelined 8-record bitonic merge network, one merge per clock, latency 3.
//
// Merges two ascending 4-record blocks into one ascending 8-record sequence.
// Block B is fed in reversed so that A followed by reversed B is bitonic.
// Three compare-exchange stages are registered one after another. The
// sideband fields travel through matching 3-deep delay lines.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_elems_0       block A, 4 ascending records, slot 0 smallest
//   i_elems_1       block B, same format as block A
//   top_tuple       sideband tuple, passed through unchanged
//   stall           bubble tag for this cycle's input (1 = invalid)
//   switch_output   sideband select flag, passed through
//   o_elems_0       lower 4 merged records, ascending
//   o_elems_1       upper 4 merged records, ascending
//   o_top_tuple     top_tuple delayed by 3 clocks
//   o_stall         stall delayed by 3 clocks; reads 1 during reset
//   o_switch_output switch_output delayed by 3 clocks
module bitonic_network_8 #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 80
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*DATA_WIDTH-1:0] i_elems_0,
  input  logic [4*DATA_WIDTH-1:0] i_elems_1,
  input  logic [4*DATA_WIDTH-1:0] top_tuple,
  input  logic                    stall,
  input  logic                    switch_output,
  output logic [4*DATA_WIDTH-1:0] o_elems_0,
  output logic [4*DATA_WIDTH-1:0] o_elems_1,
  output logic [4*DATA_WIDTH-1:0] o_top_tuple,
  output logic                    o_stall,
  output logic                    o_switch_output
);

  typedef logic [DATA_WIDTH-1:0] rec_t;

  rec_t x_in [8];
  rec_t s1_d [8];
  rec_t s1_q [8];
  rec_t s2_d [8];
  rec_t s2_q [8];
  rec_t s3_d [8];
  rec_t s3_q [8];

  logic [4*DATA_WIDTH-1:0] tuple_q [3];
  logic [2:0]              stall_q;
  logic [2:0]              switch_q;

  // Ties do not swap, so the lower-index record stays low.
  function automatic logic needs_swap(rec_t lo, rec_t hi);
    return lo[KEY_WIDTH-1:0] > hi[KEY_WIDTH-1:0];
  endfunction

  // x0..x7 = A0..A3, B3..B0
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      x_in[k]     = i_elems_0[k*DATA_WIDTH +: DATA_WIDTH];
      x_in[7 - k] = i_elems_1[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 1: distance-4 pairs
  always_comb begin
    s1_d = x_in;
    for (int i = 0; i < 4; i++) begin
      if (needs_swap(x_in[i], x_in[i+4])) begin
        s1_d[i]   = x_in[i+4];
        s1_d[i+4] = x_in[i];
      end
    end
  end

  // Stage 2: distance-2 pairs (0,2) (1,3) (4,6) (5,7)
  always_comb begin
    s2_d = s1_q;
    for (int g = 0; g < 2; g++) begin
      for (int o = 0; o < 2; o++) begin
        if (needs_swap(s1_q[4*g+o], s1_q[4*g+o+2])) begin
          s2_d[4*g+o]   = s1_q[4*g+o+2];
          s2_d[4*g+o+2] = s1_q[4*g+o];
        end
      end
    end
  end

  // Stage 3: adjacent pairs (0,1) (2,3) (4,5) (6,7)
  always_comb begin
    s3_d = s2_q;
    for (int p = 0; p < 4; p++) begin
      if (needs_swap(s2_q[2*p], s2_q[2*p+1])) begin
        s3_d[2*p]   = s2_q[2*p+1];
        s3_d[2*p+1] = s2_q[2*p];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= '{default: '0};
      s2_q     <= '{default: '0};
      s3_q     <= '{default: '0};
      tuple_q  <= '{default: '0};
      // Zeroed data in flight is tagged as bubbles.
      stall_q  <= 3'b111;
      switch_q <= 3'b000;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      tuple_q[0] <= top_tuple;
      tuple_q[1] <= tuple_q[0];
      tuple_q[2] <= tuple_q[1];
      stall_q    <= {stall_q[1:0], stall};
      switch_q   <= {switch_q[1:0], switch_output};
    end
  end

  always_comb begin
    o_elems_0 = '0;
    o_elems_1 = '0;
    for (int k = 0; k < 4; k++) begin
      o_elems_0[k*DATA_WIDTH +: DATA_WIDTH] = s3_q[k];
      o_elems_1[k*DATA_WIDTH +: DATA_WIDTH] = s3_q[k+4];
    end
    o_top_tuple     = tuple_q[2];
    o_stall         = stall_q[2];
    o_switch_output = switch_q[2];
  end

endmodule

// File: tb/tb_bitonic_network_8.sv
module tb_bitonic_network_8;

  localparam int DW = 16;
  localparam int KW = 8;
  localparam int NW = 4 * DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [NW-1:0] i_elems_0 = '0;
  logic [NW-1:0] i_elems_1 = '0;
  logic [NW-1:0] top_tuple = '0;
  logic          stall = 1'b0;
  logic          switch_output = 1'b0;
  logic [NW-1:0] o_elems_0;
  logic [NW-1:0] o_elems_1;
  logic [NW-1:0] o_top_tuple;
  logic          o_stall;
  logic          o_switch_output;

  bitonic_network_8 #(
    .DATA_WIDTH(DW),
    .KEY_WIDTH (KW)
  ) u_dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_elems_0      (i_elems_0),
    .i_elems_1      (i_elems_1),
    .top_tuple      (top_tuple),
    .stall          (stall),
    .switch_output  (switch_output),
    .o_elems_0      (o_elems_0),
    .o_elems_1      (o_elems_1),
    .o_top_tuple    (o_top_tuple),
    .o_stall        (o_stall),
    .o_switch_output(o_switch_output)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NW-1:0] e0;
    logic [NW-1:0] e1;
    logic [NW-1:0] tup;
    logic          st;
    logic          sw;
    longint        due;
  } exp_t;

  exp_t   exp_q[$];
  longint edge_cnt = 0;
  int     errors = 0;
  int     checks = 0;

  task automatic check_eq(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: stable insertion sort of A0..A3,B0..B3 by key. Test vectors
  // either use distinct keys or have ties whose network order matches this.
  function automatic void merge_model(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                      output logic [NW-1:0] lo, output logic [NW-1:0] hi);
    logic [DW-1:0] v[8];
    logic [DW-1:0] t;
    int j;
    for (int k = 0; k < 4; k++) begin
      v[k]   = a[k*DW +: DW];
      v[k+4] = b[k*DW +: DW];
    end
    for (int i = 1; i < 8; i++) begin
      t = v[i];
      j = i;
      while (j > 0 && v[j-1][KW-1:0] > t[KW-1:0]) begin
        v[j] = v[j-1];
        j--;
      end
      v[j] = t;
    end
    for (int k = 0; k < 4; k++) begin
      lo[k*DW +: DW] = v[k];
      hi[k*DW +: DW] = v[k+4];
    end
  endfunction

  function automatic logic [NW-1:0] mk_blk(input logic [7:0] k0, input logic [7:0] k1,
                                           input logic [7:0] k2, input logic [7:0] k3);
    return {k3 ^ 8'hA5, k3, k2 ^ 8'hA5, k2, k1 ^ 8'hA5, k1, k0 ^ 8'hA5, k0};
  endfunction

  // Scoreboard push: every capture edge out of reset enters one merge.
  always @(posedge i_clk) begin
    exp_t e;
    edge_cnt = edge_cnt + 1;
    if (i_rst_n) begin
      merge_model(i_elems_0, i_elems_1, e.e0, e.e1);
      e.tup = top_tuple;
      e.st  = stall;
      e.sw  = switch_output;
      e.due = edge_cnt + 2;
      exp_q.push_back(e);
    end
  end

  // Reset discards everything in flight.
  always @(negedge i_rst_n) exp_q.delete();

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front();
        check_eq("lo", o_elems_0, e.e0);
        check_eq("hi", o_elems_1, e.e1);
        check_eq("tuple", o_top_tuple, e.tup);
        check_eq("stall", NW'(o_stall), NW'(e.st));
        check_eq("switch", NW'(o_switch_output), NW'(e.sw));
      end else begin
        // Nothing captured yet since reset: only zeroed bubbles may appear.
        check_eq("bubble_stall", NW'(o_stall), NW'(1'b1));
        check_eq("bubble_lo", o_elems_0, '0);
        check_eq("bubble_tuple", o_top_tuple, '0);
      end
    end
  end

  task automatic drive(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic [NW-1:0] tup,
                       input logic st, input logic sw);
    @(negedge i_clk);
    i_elems_0     = a;
    i_elems_1     = b;
    top_tuple     = tup;
    stall         = st;
    switch_output = sw;
  endtask

  task automatic sort4(inout logic [7:0] k[4]);
    logic [7:0] t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (k[j] > k[j+1]) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
  endtask

  // Eight distinct keys split into two sorted blocks.
  task automatic rand_blocks(output logic [NW-1:0] a, output logic [NW-1:0] b);
    logic [7:0] ka[4];
    logic [7:0] kb[4];
    logic [7:0] off;
    logic [7:0] stride;
    off    = 8'($urandom_range(0, 255));
    stride = 8'(2 * $urandom_range(0, 127) + 1);
    for (int i = 0; i < 4; i++) begin
      ka[i] = off + 8'(i) * stride;
      kb[i] = off + 8'(i + 4) * stride;
    end
    sort4(ka);
    sort4(kb);
    a = mk_blk(ka[0], ka[1], ka[2], ka[3]);
    b = mk_blk(kb[0], kb[1], kb[2], kb[3]);
  endtask

  task automatic wait_result();
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [NW-1:0] a;
    logic [NW-1:0] b;

    // Reset with nonzero inputs
    i_elems_0     = '1;
    i_elems_1     = '1;
    top_tuple     = '1;
    switch_output = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_lo", o_elems_0, '0);
    check_eq("rst_hi", o_elems_1, '0);
    check_eq("rst_tuple", o_top_tuple, '0);
    check_eq("rst_stall", NW'(o_stall), NW'(1'b1));
    check_eq("rst_switch", NW'(o_switch_output), NW'(1'b0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Interleaved blocks
    drive(mk_blk(1, 3, 5, 7), mk_blk(2, 4, 6, 8), '0, 1'b0, 1'b0);
    wait_result();
    check_eq("interleave_lo", o_elems_0, mk_blk(1, 2, 3, 4));
    check_eq("interleave_hi", o_elems_1, mk_blk(5, 6, 7, 8));
    check_eq("interleave_stall", NW'(o_stall), NW'(1'b0));

    // Disjoint blocks, B entirely below A
    drive(mk_blk(10, 11, 12, 13), mk_blk(1, 2, 3, 4), '0, 1'b0, 1'b0);
    wait_result();
    check_eq("disjoint_lo", o_elems_0, mk_blk(1, 2, 3, 4));
    check_eq("disjoint_hi", o_elems_1, mk_blk(10, 11, 12, 13));

    // Equal keys with distinct payloads
    drive({16'h0407, 16'h0306, 16'h0205, 16'h0105},
          {16'hD00A, 16'hC009, 16'hB006, 16'hA005}, '0, 1'b0, 1'b0);
    wait_result();
    check_eq("ties_lo", o_elems_0, {16'h0306, 16'hA005, 16'h0205, 16'h0105});
    check_eq("ties_hi", o_elems_1, {16'hD00A, 16'hC009, 16'h0407, 16'hB006});

    // Streaming with stall on cycles 2 and 3
    for (int i = 0; i < 8; i++) begin
      rand_blocks(a, b);
      drive(a, b, NW'(i), (i == 2 || i == 3), i[0]);
    end
    for (int i = 0; i < 6; i++) begin
      rand_blocks(a, b);
      drive(a, b, NW'(100 + i), 1'b0, 1'b1);
    end

    // Mid-stream reset between edges with merges in flight
    for (int i = 0; i < 3; i++) begin
      rand_blocks(a, b);
      drive(a, b, NW'(200 + i), 1'b0, 1'b1);
    end
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_lo", o_elems_0, '0);
    check_eq("midrst_hi", o_elems_1, '0);
    check_eq("midrst_tuple", o_top_tuple, '0);
    check_eq("midrst_stall", NW'(o_stall), NW'(1'b1));
    check_eq("midrst_switch", NW'(o_switch_output), NW'(1'b0));
    #3;
    i_rst_n = 1'b1;

    // Post-release traffic; the bubble checks cover stale data
    for (int i = 0; i < 4; i++) begin
      rand_blocks(a, b);
      drive(a, b, NW'(300 + i), 1'b0, i[0]);
    end
    drive('0, '0, '0, 1'b1, 1'b0);
    repeat (5) @(negedge i_clk);
    #1;
    // Held inputs keep entering; only the two newest may still be pending.
    check_eq("drain", NW'(exp_q.size()), NW'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitonic_network_8.md
Name: bitonic_network_8

Overview:
- Fully pipelined 8-record bitonic merge network, one merge per clock.
- Inputs are two sorted 4-record blocks. Outputs are the lower 4 and the upper 4 records of the merged, sorted 8-record sequence.
- Carries three sideband fields, delayed to stay aligned with the data: a pass-through tuple, a stall/bubble flag and an output-select flag.
- Used as a stage inside the 4-wide merger datapath; two instances are chained there.

Parameters:
DATA_WIDTH, 128, width of one record in bits
KEY_WIDTH, 80, sort key width; the key is bits [KEY_WIDTH-1:0] of each record (KEY_WIDTH <= DATA_WIDTH)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_elems_0  input  4*DATA_WIDTH  block A, 4 records sorted ascending; slot k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; slot 0 holds the smallest
i_elems_1  input  4*DATA_WIDTH  block B, same format and ordering as block A
top_tuple  input  4*DATA_WIDTH  sideband tuple, passed through unmodified
stall  input  1  bubble marker for this cycle's input (1 = invalid)
switch_output  input  1  sideband select flag, passed through
o_elems_0  output  4*DATA_WIDTH  4 smallest merged records, ascending, slot 0 smallest
o_elems_1  output  4*DATA_WIDTH  4 largest merged records, ascending, slot 0 smallest of the upper half
o_top_tuple  output  4*DATA_WIDTH  top_tuple delayed by the network latency
o_stall  output  1  stall delayed by the network latency
o_switch_output  output  1  switch_output delayed by the network latency

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- While reset is asserted, and immediately on assertion:
  - every pipeline register clears to 0;
  - o_elems_0, o_elems_1 and o_top_tuple read 0;
  - o_switch_output reads 0;
  - o_stall reads 1, so zeroed data is marked as a bubble.
- Reset asserted mid-stream discards all in-flight data.
- Merge input ordering: form x0..x7 = A0, A1, A2, A3, B3, B2, B1, B0. B is reversed so the sequence is bitonic.
- Compare-exchange rule, for a pair (i, j) with i < j:
  - compare only key bits [KEY_WIDTH-1:0], unsigned;
  - if key(xi) <= key(xj) the pair is unchanged, otherwise the two full records swap;
  - the full record (key plus payload bits) always moves as a unit.
- Stage 1: pairs (0,4) (1,5) (2,6) (3,7).
- Stage 2: pairs (0,2) (1,3) (4,6) (5,7).
- Stage 3: pairs (0,1) (2,3) (4,5) (6,7).
- Pipelining and latency:
  - each stage's result is registered, so latency is exactly 3 clocks;
  - throughput is one merge per clock, with no internal back-pressure.
- Output mapping: o_elems_0 slot k = x_k, and o_elems_1 slot k = x_(k+4), taken after stage 3.
- Sideband: top_tuple, stall and switch_output each go through a 3-register delay line, exactly aligned with the data.
- Stall semantics:
  - stall does NOT freeze the pipeline; it is a valid/bubble tag only;
  - data entered with stall=1 is still computed and emerges with o_stall=1;
  - downstream uses o_stall to suppress writes.
- Equal keys: no swap, so the record from the lower-index position stays low. This gives deterministic output.
- All-zero records are ordinary records with key 0; zero is the stream terminator and sorts first.
- The output is correct only if both inputs are sorted ascending; for unsorted input the output is the network's deterministic permutation, with no error flag.
- No combinational path from any input to any output.

Test Plan (DATA_WIDTH=16, KEY_WIDTH=8; "{...}" lists keys in slots 0..3; payload = upper 8 bits unless noted):
- Reset: assert i_rst_n=0 with nonzero inputs -> o_elems_0, o_elems_1 and o_top_tuple = 0, o_stall=1, o_switch_output=0. Release reset, drive A={1,3,5,7}, B={2,4,6,8}, stall=0 -> 3 clocks later o_elems_0={1,2,3,4}, o_elems_1={5,6,7,8}, o_stall=0.
- Disjoint blocks: A={10,11,12,13}, B={1,2,3,4} -> o_elems_0={1,2,3,4} (B), o_elems_1={10,11,12,13} (A), after exactly 3 clocks.
- Payload and equal keys:
  - stimulus: A records 0x0105, 0x0205, 0x0306, 0x0407; B records 0xA005, 0xB006, 0xC009, 0xD00A;
  - o_elems_0 keys {5,5,5,6}, o_elems_1 keys {6,7,9,10};
  - every 16-bit record appears exactly once, and each payload stays attached to its own key.
- Streaming: a different A/B pair each cycle for 8 cycles, with top_tuple=cycle index and switch_output toggling -> each result appears 3 cycles later, in order. o_top_tuple and o_switch_output match their inputs from 3 cycles earlier.
- Stall tagging: stall=1 on cycles 2 and 3 only -> o_stall=1 on cycles 5 and 6, 0 elsewhere. Data for cycles 2 and 3 still emerges, merged, on cycles 5 and 6.
- Mid-stream reset: pulse i_rst_n low asynchronously, between edges, while 3 merges are in flight -> outputs clear immediately and o_stall=1. No pre-reset data appears after release.
